rob_commit: RTL and testbench
=============================

# rob_commit

Reorder buffer and in-order commit stage of the Tomasulo core. Sits downstream of the decode/issue stage: it hands decode a destination tag for each issued instruction, captures results broadcast on the common data bus (CDB), and retires instructions in program order to the architectural register file / RAT. Each retirement is a one-cycle commit pulse that lets the RAT clear its busy bit when the tags match.

## Interface
Parameters:
- DEPTH, 8: number of ROB entries. Must be a power of two, 2..16.
- TAG_W, 4: tag width. Tag = slot index + 1; tag 0 means "no tag".
- DATA_W, 32: result width.
- REG_W, 5: architectural register index width.
- TYPE_W, 3: instruction type code width.

Ports (clock and reset first):
- clk1, in, 1: the single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- alloc_valid, in, 1: decode requests an entry.
- alloc_ready, out, 1: an entry is free; the allocation takes effect when valid and ready are both high at a clock edge.
- alloc_type, in, TYPE_W: instruction type code.
- alloc_rd, in, REG_W: destination register.
- alloc_tag, out, TAG_W: tag of the tail slot. Combinational, valid whenever alloc_ready is high.
- cdb_valid, in, 1: a result is being broadcast.
- cdb_tag, in, TAG_W: producer tag of the broadcast.
- cdb_value, in, DATA_W: result value.
- commit_valid, out, 1: one-cycle retire pulse.
- commit_tag, out, TAG_W: tag of the retiring entry.
- commit_rd, out, REG_W: destination register of the retiring entry.
- commit_value, out, DATA_W: result of the retiring entry.
- count, out, TAG_W: number of occupied entries, 0..DEPTH.

## Operation
- Per-entry state: busy, done, type, rd, value.
- Pointers: head and tail, log2(DEPTH) bits each, wrapping modulo DEPTH. Occupancy is tracked in count.
- Allocate:
  - On alloc_valid && alloc_ready: entry[tail] gets busy=1, done=0, type, rd, value=0.
  - tail increments.
- Writeback:
  - On cdb_valid, with cdb_tag in 1..DEPTH and entry[cdb_tag-1] busy and not done: that entry gets value=cdb_value and done=1.
  - Tag 0, a non-busy slot, or an already-done slot: the broadcast is ignored with no state change.
- Commit:
  - When entry[head] is busy && done, the next edge frees the slot (busy=0), increments head, and registers the commit outputs with commit_valid=1.
  - At most one retirement per cycle.
- Per-cycle state machine, derived from count:
  - EMPTY (count=0): no commit possible.
  - PARTIAL: normal operation.
  - FULL (count=DEPTH): alloc_ready=0.
- Count update: +1 on allocate only, −1 on commit only, unchanged when both happen.
- alloc_ready = (count != DEPTH). It does not depend on a same-cycle commit, so there is no pass-through when full.
- Writeback aimed at the tail slot in the same cycle as its allocation is impossible: that slot is not busy yet, so the broadcast is ignored.

## Timing
- Reset (asynchronous): all busy/done bits = 0, head = tail = 0, count = 0. Outputs: commit_valid=0, commit_tag=0, commit_rd=0, commit_value=0, alloc_ready=1, alloc_tag=1.
- Reset asserted mid-operation discards every entry immediately; no commit pulse is produced for discarded entries.
- Allocate-to-tag: alloc_tag is combinational from tail. The new entry is visible after the allocating edge.
- CDB-to-commit latency:
  - Default: CDB captured at edge N; commit_valid is high for the cycle after edge N+1.
- commit_valid is high for exactly one cycle per retirement. Back-to-back retirements produce consecutive pulses.

## Configuration
- ROB_CDB_BYPASS_EN defined:
  - If cdb_valid and cdb_tag equals the head tag, with the head busy and not done, retirement happens at edge N directly.
  - commit_value is taken from cdb_value.
  - Latency from CDB to commit is 1 cycle.
- ROB_CDB_BYPASS_EN undefined: the result is always written to the entry first, and the latency is 2 cycles.
- All other behaviour is identical in both builds.

## Structure
- Shared package tomasulo_pkg holds:
  - Type codes: LOAD=3'b001, ADD=3'b010, SUB=3'b011, MUL=3'b100, DIV=3'b101.
  - Defaults for DEPTH, TAG_W, DATA_W and REG_W.
  - The ROB entry struct (busy, done, type, rd, value).
- Sub-module rob_slot: one entry register holding the allocate/writeback/free logic, instantiated DEPTH times.
- Pointers, count and the commit output registers live in rob_commit.

## Test plan
- Reset with entries occupied: after rst_n low then high, count=0, alloc_tag=1, commit_valid=0 with no pulse.
- Allocate ADD, rd=5, tag 1; CDB tag=1, value=0x2A → one commit pulse, rd=5, value=0x2A, tag=1. It occurs 2 cycles after the CDB (1 cycle with bypass).
- Out-of-order completion: allocate tags 1, 2, 3. CDB writes tag 3, then 2, then 1 → commits come out in order 1, 2, 3, on consecutive cycles.
- Full: 8 allocates → alloc_ready=0, count=8. A 9th request is held. Committing tag 1 allows the next allocation, which gets alloc_tag=1 (wrap-around).
- Simultaneous allocate and commit at count=4 → count stays 4, both take effect.
- CDB with tag 0, tag of a free slot, or a repeated tag of a done entry → no state change and no commit; the stored value is unchanged.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions used by the reorder buffer slice.
// Contents:
//   - instruction type codes
//   - default ROB geometry
//   - the ROB entry record
//   - the occupancy state and its derivation from the entry count
package tomasulo_pkg;

  localparam int unsigned ROB_DEPTH  = 8;
  localparam int unsigned ROB_TAG_W  = 4;
  localparam int unsigned ROB_DATA_W = 32;
  localparam int unsigned ROB_REG_W  = 5;
  localparam int unsigned ROB_TYPE_W = 3;

  typedef enum logic [ROB_TYPE_W-1:0] {
    LOAD = 3'b001,
    ADD  = 3'b010,
    SUB  = 3'b011,
    MUL  = 3'b100,
    DIV  = 3'b101
  } instr_type_e;

  typedef struct packed {
    logic                  busy;
    logic                  done;
    logic [ROB_TYPE_W-1:0] itype;
    logic [ROB_REG_W-1:0]  rd;
    logic [ROB_DATA_W-1:0] value;
  } rob_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_state_e;

  function automatic occ_state_e occ_state(input int unsigned cnt, input int unsigned depth);
    if (cnt == 0)     return OCC_EMPTY;
    if (cnt >= depth) return OCC_FULL;
    return OCC_PARTIAL;
  endfunction

endpackage

// File: rtl/rob_commit_if.sv
// Decode / CDB / commit bundle of the reorder buffer.
// master: decode/issue + CDB side (drives allocation requests and broadcasts,
//         observes tags, occupancy and retirements).
// slave : the reorder buffer itself.
// Signals:
//   alloc_valid/alloc_ready/alloc_type/alloc_rd/alloc_tag - entry allocation
//   cdb_valid/cdb_tag/cdb_value                           - result broadcast
//   commit_valid/commit_tag/commit_rd/commit_value        - retire pulse
//   count                                                 - occupied entries
interface rob_commit_if
  import tomasulo_pkg::*;
#(
  parameter int unsigned TAG_W  = ROB_TAG_W,
  parameter int unsigned DATA_W = ROB_DATA_W,
  parameter int unsigned REG_W  = ROB_REG_W,
  parameter int unsigned TYPE_W = ROB_TYPE_W
);

  logic              alloc_valid;
  logic              alloc_ready;
  logic [TYPE_W-1:0] alloc_type;
  logic [REG_W-1:0]  alloc_rd;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              commit_valid;
  logic [TAG_W-1:0]  commit_tag;
  logic [REG_W-1:0]  commit_rd;
  logic [DATA_W-1:0] commit_value;
  logic [TAG_W-1:0]  count;

  modport master (
    output alloc_valid, alloc_type, alloc_rd, cdb_valid, cdb_tag, cdb_value,
    input  alloc_ready, alloc_tag, commit_valid, commit_tag, commit_rd, commit_value, count
  );

  modport slave (
    input  alloc_valid, alloc_type, alloc_rd, cdb_valid, cdb_tag, cdb_value,
    output alloc_ready, alloc_tag, commit_valid, commit_tag, commit_rd, commit_value, count
  );

endinterface

// File: rtl/rob_slot.sv
// One reorder buffer entry.
// Ports:
//   clk_i, rst_n           - clock, asynchronous active-low reset
//   alloc_i                - claim this slot (type/rd captured, value cleared)
//   alloc_type_i/alloc_rd_i - instruction type and destination register
//   cdb_valid_i/cdb_tag_i/cdb_value_i - result broadcast; captured only when
//                            the tag is SLOT_TAG and the slot is busy, not done
//   free_i                 - retire this slot
//   entry_o                - current entry contents
module rob_slot
  import tomasulo_pkg::*;
#(
  parameter int unsigned TAG_W    = ROB_TAG_W,
  parameter int unsigned SLOT_TAG = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  alloc_i,
  input  logic [ROB_TYPE_W-1:0] alloc_type_i,
  input  logic [ROB_REG_W-1:0]  alloc_rd_i,
  input  logic                  cdb_valid_i,
  input  logic [TAG_W-1:0]      cdb_tag_i,
  input  logic [ROB_DATA_W-1:0] cdb_value_i,
  input  logic                  free_i,
  output rob_entry_t            entry_o
);

  rob_entry_t entry_q, entry_d;
  logic       wb_hit;

  assign wb_hit = cdb_valid_i && (cdb_tag_i == TAG_W'(SLOT_TAG)) &&
                  entry_q.busy && !entry_q.done;

  // free and alloc never target the same slot in one cycle (that would need
  // the buffer to be both full and empty); free wins so a bypassed result
  // arriving on the retiring edge does not leave a stale done bit behind.
  always_comb begin
    entry_d = entry_q;
    if (free_i) begin
      entry_d.busy = 1'b0;
      entry_d.done = 1'b0;
    end else if (alloc_i) begin
      entry_d.busy  = 1'b1;
      entry_d.done  = 1'b0;
      entry_d.itype = alloc_type_i;
      entry_d.rd    = alloc_rd_i;
      entry_d.value = '0;
    end else if (wb_hit) begin
      entry_d.done  = 1'b1;
      entry_d.value = cdb_value_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) entry_q <= '0;
    else        entry_q <= entry_d;
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer with in-order commit.
// Hands decode the tail tag, captures CDB results into entries and retires the
// head entry as a registered one-cycle commit pulse.
// Ports:
//   clk1  - clock
//   rst_n - asynchronous active-low reset; discards all entries
//   rob   - rob_commit_if.slave (allocation, CDB, commit, count)
// Build option: ROB_CDB_BYPASS_EN lets a CDB result aimed at a pending head
// retire on the same edge it is broadcast (1-cycle CDB-to-commit instead of 2).
module rob_commit
  import tomasulo_pkg::*;
#(
  parameter int unsigned DEPTH  = ROB_DEPTH,
  parameter int unsigned TAG_W  = ROB_TAG_W,
  parameter int unsigned DATA_W = ROB_DATA_W,
  parameter int unsigned REG_W  = ROB_REG_W,
  parameter int unsigned TYPE_W = ROB_TYPE_W
) (
  input logic         clk1,
  input logic         rst_n,
  rob_commit_if.slave rob
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  rob_entry_t        entry [DEPTH];
  logic [DEPTH-1:0]  alloc_vec;
  logic [DEPTH-1:0]  free_vec;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [TAG_W-1:0]  count_q, count_d;
  occ_state_e        state_q, state_d;

  logic              commit_valid_q;
  logic [TAG_W-1:0]  commit_tag_q;
  logic [REG_W-1:0]  commit_rd_q;
  logic [DATA_W-1:0] commit_value_q;

  rob_entry_t        head_entry;
  logic [TAG_W-1:0]  head_tag;
  logic              head_ready;
  logic              do_alloc;
  logic              do_commit;
  logic [DATA_W-1:0] retire_value;
  logic [TYPE_W-1:0] head_type_unused;

  assign head_entry       = entry[head_q];
  assign head_tag         = TAG_W'(head_q) + TAG_W'(1);
  assign head_ready       = head_entry.busy && head_entry.done;
  assign head_type_unused = TYPE_W'(head_entry.itype);

  // Ready comes from registered occupancy only: a full buffer never accepts
  // an allocation on the edge that frees the head.
  assign do_alloc = rob.alloc_valid && (state_q != OCC_FULL);

`ifdef ROB_CDB_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit   = rob.cdb_valid && (rob.cdb_tag == head_tag) &&
                        head_entry.busy && !head_entry.done;
  assign do_commit    = (state_q != OCC_EMPTY) && (head_ready || bypass_hit);
  assign retire_value = head_ready ? DATA_W'(head_entry.value) : rob.cdb_value;
`else
  assign do_commit    = (state_q != OCC_EMPTY) && head_ready;
  assign retire_value = DATA_W'(head_entry.value);
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign alloc_vec[i] = do_alloc  && (tail_q == PTR_W'(i));
    assign free_vec[i]  = do_commit && (head_q == PTR_W'(i));

    rob_slot #(
      .TAG_W    (TAG_W),
      .SLOT_TAG (i + 1)
    ) u_slot (
      .clk_i        (clk1),
      .rst_n        (rst_n),
      .alloc_i      (alloc_vec[i]),
      .alloc_type_i (ROB_TYPE_W'(rob.alloc_type)),
      .alloc_rd_i   (ROB_REG_W'(rob.alloc_rd)),
      .cdb_valid_i  (rob.cdb_valid),
      .cdb_tag_i    (rob.cdb_tag),
      .cdb_value_i  (ROB_DATA_W'(rob.cdb_value)),
      .free_i       (free_vec[i]),
      .entry_o      (entry[i])
    );
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_alloc)  tail_d = tail_q + 1'b1;
    if (do_commit) head_d = head_q + 1'b1;
    case ({do_alloc, do_commit})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    state_d = occ_state(32'(count_d), DEPTH);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      state_q        <= OCC_EMPTY;
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      state_q        <= state_d;
      commit_valid_q <= do_commit;
      if (do_commit) begin
        commit_tag_q   <= head_tag;
        commit_rd_q    <= REG_W'(head_entry.rd);
        commit_value_q <= retire_value;
      end
    end
  end

  assign rob.alloc_ready  = (state_q != OCC_FULL);
  assign rob.alloc_tag    = TAG_W'(tail_q) + TAG_W'(1);
  assign rob.count        = count_q;
  assign rob.commit_valid = commit_valid_q;
  assign rob.commit_tag   = commit_tag_q;
  assign rob.commit_rd    = commit_rd_q;
  assign rob.commit_value = commit_value_q;

endmodule

// File: tb/tb_rob_commit.sv
// Self-checking bench for rob_commit: directed scenarios plus a randomized run
// against a program-order queue model of the reorder buffer.
module tb_rob_commit;
  import tomasulo_pkg::*;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned TYPE_W = 3;
`ifdef ROB_CDB_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_commit_if #(.TAG_W(TAG_W), .DATA_W(DATA_W), .REG_W(REG_W), .TYPE_W(TYPE_W)) bus ();

  rob_commit #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .REG_W(REG_W), .TYPE_W(TYPE_W)
  ) dut (
    .clk1  (clk),
    .rst_n (rst_n),
    .rob   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Program-order model: live instructions oldest first.
  typedef struct {
    int unsigned tag;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] value;
  } mrec_t;

  mrec_t       mq[$];
  int unsigned m_next_tag;
  bit          exp_cv;
  int unsigned exp_ctag;
  logic [4:0]  exp_crd;
  logic [31:0] exp_cval;

  task automatic idle_inputs();
    bus.alloc_valid = 1'b0;
    bus.alloc_type  = ADD;
    bus.alloc_rd    = '0;
    bus.cdb_valid   = 1'b0;
    bus.cdb_tag     = '0;
    bus.cdb_value   = '0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_next_tag = 1;
    exp_cv     = 1'b0;
    exp_ctag   = 0;
    exp_crd    = '0;
    exp_cval   = '0;
  endtask

  // Applies the current inputs to the model as one clock edge.
  task automatic model_edge();
    bit com;
    com = 1'b0;
    if (mq.size() != 0) begin
      if (mq[0].done) com = 1'b1;
`ifdef ROB_CDB_BYPASS_EN
      else if (bus.cdb_valid && 32'(bus.cdb_tag) == mq[0].tag) begin
        com = 1'b1;
        mq[0].value = bus.cdb_value;
      end
`endif
    end
    exp_cv = com;
    if (com) begin
      exp_ctag = mq[0].tag;
      exp_crd  = mq[0].rd;
      exp_cval = mq[0].value;
    end
    if (bus.cdb_valid)
      foreach (mq[i])
        if (mq[i].tag == 32'(bus.cdb_tag) && !mq[i].done) begin
          mq[i].done  = 1'b1;
          mq[i].value = bus.cdb_value;
        end
    if (bus.alloc_valid && mq.size() < DEPTH) begin
      mq.push_back('{tag: m_next_tag, rd: bus.alloc_rd, done: 1'b0, value: 32'h0});
      m_next_tag = (m_next_tag == DEPTH) ? 1 : m_next_tag + 1;
    end
    if (com) void'(mq.pop_front());
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic alloc_n(input int n, input int rd_base);
    bus.alloc_valid = 1'b1;
    bus.alloc_type  = ADD;
    for (int i = 0; i < n; i++) begin
      bus.alloc_rd = 5'(rd_base + i);
      cycle();
    end
    bus.alloc_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.count !== 4'd0) $display("FAIL reset_count: got %0d want 0", bus.count); else n_pass++;
    n_checks++; if (bus.alloc_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.alloc_ready); else n_pass++;
    n_checks++; if (bus.alloc_tag !== 4'd1) $display("FAIL reset_tag: got %0d want 1", bus.alloc_tag); else n_pass++;
    n_checks++; if (bus.commit_valid !== 1'b0) $display("FAIL reset_cv: got %b want 0", bus.commit_valid); else n_pass++;
    alloc_n(3, 1);
    bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd2; bus.cdb_value = 32'h22; cycle();
    bus.cdb_tag = 4'd1; bus.cdb_value = 32'h11; cycle();
    idle_inputs();
    // a retirement is now pending for the next edge; reset must swallow it
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (bus.count !== 4'd0) $display("FAIL midreset_count: got %0d want 0", bus.count); else n_pass++;
    n_checks++; if (bus.commit_valid !== 1'b0) $display("FAIL midreset_cv: got %b want 0", bus.commit_valid); else n_pass++;
    n_checks++; if (bus.alloc_tag !== 4'd1) $display("FAIL midreset_tag: got %0d want 1", bus.alloc_tag); else n_pass++;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++; if (bus.commit_valid !== 1'b0) $display("FAIL postreset_pulse: got %b want 0 (cycle %0d)", bus.commit_valid, i); else n_pass++;
    end
    n_checks++; if (bus.count !== 4'd0) $display("FAIL postreset_count: got %0d want 0", bus.count); else n_pass++;
  endtask

  task automatic test_basic();
    int lat;
    logic [3:0]  t;
    logic [4:0]  r;
    logic [31:0] v;
    do_reset();
    n_checks++; if (bus.alloc_tag !== 4'd1) $display("FAIL basic_alloc_tag: got %0d want 1", bus.alloc_tag); else n_pass++;
    bus.alloc_valid = 1'b1; bus.alloc_type = ADD; bus.alloc_rd = 5'd5;
    cycle();
    bus.alloc_valid = 1'b0;
    n_checks++; if (bus.count !== 4'd1) $display("FAIL basic_count: got %0d want 1", bus.count); else n_pass++;
    bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd1; bus.cdb_value = 32'h2A;
    cycle();
    idle_inputs();
    lat = 0; t = '0; r = '0; v = '0;
    for (int k = 1; k <= 4 && lat == 0; k++) begin
      if (bus.commit_valid === 1'b1) begin
        lat = k; t = bus.commit_tag; r = bus.commit_rd; v = bus.commit_value;
      end else cycle();
    end
    n_checks++; if (lat != EXP_LAT) $display("FAIL basic_latency: got %0d want %0d", lat, EXP_LAT); else n_pass++;
    n_checks++; if (t !== 4'd1) $display("FAIL basic_commit_tag: got %0d want 1", t); else n_pass++;
    n_checks++; if (r !== 5'd5) $display("FAIL basic_commit_rd: got %0d want 5", r); else n_pass++;
    n_checks++; if (v !== 32'h2A) $display("FAIL basic_commit_value: got %0h want 2a", v); else n_pass++;
    cycle();
    n_checks++; if (bus.commit_valid !== 1'b0) $display("FAIL basic_single_pulse: got %b want 0", bus.commit_valid); else n_pass++;
    n_checks++; if (bus.count !== 4'd0) $display("FAIL basic_count_after: got %0d want 0", bus.count); else n_pass++;
  endtask

  task automatic test_out_of_order();
    int unsigned got_tag[$];
    int          got_cyc[$];
    logic [31:0] got_val[$];
    do_reset();
    alloc_n(3, 10);
    for (int j = 0; j < 8; j++) begin
      if (j < 3) begin
        bus.cdb_valid = 1'b1; bus.cdb_tag = 4'(3 - j); bus.cdb_value = 32'h300 + 32'(3 - j);
      end else idle_inputs();
      cycle();
      if (bus.commit_valid === 1'b1) begin
        got_tag.push_back(32'(bus.commit_tag)); got_cyc.push_back(j); got_val.push_back(bus.commit_value);
      end
    end
    n_checks++; if (got_tag.size() != 3) $display("FAIL ooo_pulses: got %0d want 3", got_tag.size()); else n_pass++;
    if (got_tag.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (got_tag[i] != 32'(i + 1)) $display("FAIL ooo_order[%0d]: got %0d want %0d", i, got_tag[i], i + 1); else n_pass++;
        n_checks++; if (got_val[i] !== 32'h300 + 32'(i + 1)) $display("FAIL ooo_value[%0d]: got %0h want %0h", i, got_val[i], 32'h300 + 32'(i + 1)); else n_pass++;
      end
      n_checks++; if (got_cyc[0] != 1 + EXP_LAT) $display("FAIL ooo_first_cycle: got %0d want %0d", got_cyc[0], 1 + EXP_LAT); else n_pass++;
      n_checks++; if (got_cyc[2] - got_cyc[0] != 2) $display("FAIL ooo_consecutive: got span %0d want 2", got_cyc[2] - got_cyc[0]); else n_pass++;
    end
  endtask

  task automatic test_full();
    bit seen;
    do_reset();
    alloc_n(8, 0);
    n_checks++; if (bus.count !== 4'd8) $display("FAIL full_count: got %0d want 8", bus.count); else n_pass++;
    n_checks++; if (bus.alloc_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", bus.alloc_ready); else n_pass++;
    bus.alloc_valid = 1'b1; bus.alloc_rd = 5'd31;
    cycle(); cycle();
    n_checks++; if (bus.count !== 4'd8) $display("FAIL full_held: got %0d want 8", bus.count); else n_pass++;
    bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd1; bus.cdb_value = 32'h77;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      cycle();
      bus.cdb_valid = 1'b0;
      seen = (bus.commit_valid === 1'b1);
    end
    n_checks++; if (!seen) $display("FAIL full_commit_timeout: got no pulse want pulse"); else n_pass++;
    n_checks++; if (bus.commit_tag !== 4'd1) $display("FAIL full_commit_tag: got %0d want 1", bus.commit_tag); else n_pass++;
    n_checks++; if (bus.count !== 4'd7) $display("FAIL full_no_passthrough: got %0d want 7", bus.count); else n_pass++;
    n_checks++; if (bus.alloc_tag !== 4'd1) $display("FAIL full_wrap_tag: got %0d want 1", bus.alloc_tag); else n_pass++;
    n_checks++; if (bus.alloc_ready !== 1'b1) $display("FAIL full_ready_again: got %b want 1", bus.alloc_ready); else n_pass++;
    cycle();
    idle_inputs();
    n_checks++; if (bus.count !== 4'd8) $display("FAIL full_refill_count: got %0d want 8", bus.count); else n_pass++;
    n_checks++; if (bus.alloc_tag !== 4'd2) $display("FAIL full_refill_tag: got %0d want 2", bus.alloc_tag); else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    alloc_n(4, 16);
`ifndef ROB_CDB_BYPASS_EN
    bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd1; bus.cdb_value = 32'hABC;
    cycle();
    bus.cdb_valid = 1'b0;
    n_checks++; if (bus.count !== 4'd4) $display("FAIL simul_pre_count: got %0d want 4", bus.count); else n_pass++;
`else
    bus.cdb_valid = 1'b1; bus.cdb_tag = 4'd1; bus.cdb_value = 32'hABC;
`endif
    bus.alloc_valid = 1'b1; bus.alloc_rd = 5'd20;
    cycle();
    idle_inputs();
    n_checks++; if (bus.commit_valid !== 1'b1) $display("FAIL simul_cv: got %b want 1", bus.commit_valid); else n_pass++;
    n_checks++; if (bus.commit_tag !== 4'd1) $display("FAIL simul_tag: got %0d want 1", bus.commit_tag); else n_pass++;
    n_checks++; if (bus.commit_value !== 32'hABC) $display("FAIL simul_value: got %0h want abc", bus.commit_value); else n_pass++;
    n_checks++; if (bus.count !== 4'd4) $display("FAIL simul_count: got %0d want 4", bus.count); else n_pass++;
    n_checks++; if (bus.alloc_tag !== 4'd6) $display("FAIL simul_alloc_tag: got %0d want 6", bus.alloc_tag); else n_pass++;
  endtask

  task automatic test_ignored();
    int unsigned got_tag[$];
    logic [31:0] got_val[$];
    logic [3:0]  tags [5];
    logic [31:0] vals [5];
    tags = '{4'd0, 4'd5, 4'd2, 4'd2, 4'd1};
    vals = '{32'hDEAD, 32'hBEEF, 32'h55, 32'h99, 32'h11};
    do_reset();
    alloc_n(2, 7);
    for (int j = 0; j < 4; j++) begin
      bus.cdb_valid = 1'b1; bus.cdb_tag = tags[j]; bus.cdb_value = vals[j];
      cycle();
      n_checks++; if (bus.commit_valid !== 1'b0) $display("FAIL ign_no_commit[%0d]: got %b want 0", j, bus.commit_valid); else n_pass++;
      n_checks++; if (bus.count !== 4'd2) $display("FAIL ign_count[%0d]: got %0d want 2", j, bus.count); else n_pass++;
    end
    bus.cdb_tag = tags[4]; bus.cdb_value = vals[4];
    for (int j = 0; j < 5; j++) begin
      cycle();
      idle_inputs();
      if (bus.commit_valid === 1'b1) begin
        got_tag.push_back(32'(bus.commit_tag)); got_val.push_back(bus.commit_value);
      end
    end
    n_checks++; if (got_tag.size() != 2) $display("FAIL ign_pulses: got %0d want 2", got_tag.size()); else n_pass++;
    if (got_tag.size() == 2) begin
      n_checks++; if (got_val[0] !== 32'h11) $display("FAIL ign_value1: got %0h want 11", got_val[0]); else n_pass++;
      n_checks++; if (got_tag[1] != 2) $display("FAIL ign_tag2: got %0d want 2", got_tag[1]); else n_pass++;
      n_checks++; if (got_val[1] !== 32'h55) $display("FAIL ign_value2_kept: got %0h want 55", got_val[1]); else n_pass++;
    end
  endtask

  task automatic test_random();
    instr_type_e types [5];
    int r;
    types = '{LOAD, ADD, SUB, MUL, DIV};
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.alloc_valid = ($urandom_range(0, 99) < 55);
      bus.alloc_type  = types[$urandom_range(0, 4)];
      bus.alloc_rd    = 5'($urandom);
      bus.cdb_value   = $urandom;
      r = int'($urandom_range(0, 99));
      if (r < 45 && mq.size() > 0) begin
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 4'(mq[$urandom_range(0, mq.size() - 1)].tag);
      end else if (r < 55) begin
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 4'($urandom_range(0, 15));
      end else begin
        bus.cdb_valid = 1'b0;
        bus.cdb_tag   = 4'($urandom_range(0, 15));
      end
      cycle();
      n_checks++; if (bus.commit_valid !== exp_cv) $display("FAIL rnd_cv @%0d: got %b want %b", c, bus.commit_valid, exp_cv); else n_pass++;
      if (exp_cv) begin
        n_checks++; if (32'(bus.commit_tag) !== exp_ctag) $display("FAIL rnd_tag @%0d: got %0d want %0d", c, bus.commit_tag, exp_ctag); else n_pass++;
        n_checks++; if (bus.commit_rd !== exp_crd) $display("FAIL rnd_rd @%0d: got %0d want %0d", c, bus.commit_rd, exp_crd); else n_pass++;
        n_checks++; if (bus.commit_value !== exp_cval) $display("FAIL rnd_value @%0d: got %0h want %0h", c, bus.commit_value, exp_cval); else n_pass++;
      end
      n_checks++; if (bus.count !== 4'(mq.size())) $display("FAIL rnd_count @%0d: got %0d want %0d", c, bus.count, mq.size()); else n_pass++;
      n_checks++; if (bus.alloc_ready !== (mq.size() < DEPTH)) $display("FAIL rnd_ready @%0d: got %b want %b", c, bus.alloc_ready, mq.size() < DEPTH); else n_pass++;
      n_checks++; if (bus.alloc_tag !== 4'(m_next_tag)) $display("FAIL rnd_alloc_tag @%0d: got %0d want %0d", c, bus.alloc_tag, m_next_tag); else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_basic();
    test_out_of_order();
    test_full();
    test_simultaneous();
    test_ignored();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
